nios_mem_loader: RTL and testbench
==================================

Name: nios_mem_loader

Overview:
- Upstream feeder for the Nios on-chip program/data memory (1024 x 32, single-port, byte-enabled Avalon slave).
- Receives a framed byte stream from the UART receiver, packs bytes little-endian into 32-bit words and writes them into the memory through an Avalon-MM write master.
- Holds the CPU in reset while loading, then reports the result with done/error.

Parameters:
- ADDR_W, 10, memory word-address width (depth 2^ADDR_W).
- TIMEOUT_CYCLES, 5000000, idle cycles between bytes inside a frame before the frame is aborted.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; at most one byte per cycle
- mem_address  out  ADDR_W  word address to memory
- mem_byteenable  out  4  byte lanes; lane i = writedata[8i+7:8i]
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  write data
- cpu_hold  out  1  high while a frame is in progress; drives CPU/memory reset_req
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse, frame loaded and checksum good
- error  out  1  one-cycle pulse, frame aborted or checksum bad
- err_code  out  2  0 none, 1 checksum, 2 length, 3 timeout; held until next SYNC_BYTE accepted

Behaviour:
- Reset: all outputs 0; FSM IDLE; byte counter, checksum, packing register, timeout counter cleared.
- Frame: SYNC_BYTE, ADDR_L, ADDR_H, LEN_L, LEN_H, LEN data bytes, CSUM.
- Start word address = {ADDR_H,ADDR_L}[ADDR_W-1:0]; upper bits ignored. LEN = {LEN_H,LEN_L} in bytes.
- States: IDLE -> ADDR_L -> ADDR_H -> LEN_L -> LEN_H -> DATA -> CSUM -> IDLE. Each transition happens on an rx_valid byte.
- IDLE ignores every byte except SYNC_BYTE.
- On SYNC_BYTE: cpu_hold=1 and busy=1 from the next cycle, err_code cleared.
- LEN_H check: LEN > 4*2^ADDR_W gives error with code 2 and a return to IDLE. LEN = 0 skips DATA and goes directly to CSUM.
- DATA packing: byte k of the frame goes to lane k mod 4, so each word starts at lane 0. Checksum = 8-bit modular sum of the data bytes.
- Word write, full word: after the byte that fills lane 3, the next cycle asserts mem_chipselect=mem_write=1 for exactly one cycle with byteenable=4'b1111. Address = start + word index.
- Word write, partial last word: after the last data byte, if the word is incomplete, the next cycle writes it with byteenable covering only the received lanes (e.g. 2 bytes -> 4'b0011).
- Memory has no waitrequest, so writes always complete in one cycle. The write register is separate from the packing register, so a byte arriving in the same cycle as a write is accepted without loss.
- Address wraps modulo 2^ADDR_W (1023 -> 0).
- CSUM: if the received byte equals the sum, done pulses; otherwise error pulses with code 1. Either way the next cycle is IDLE with cpu_hold=0 and busy=0. Data already written stays written.
- done/error pulse in the cycle after the CSUM byte, or after the error condition; never both in the same cycle.
- Timeout: counter clears on every rx_valid while busy. At TIMEOUT_CYCLES without a byte it issues error with code 3, then IDLE. A pending word write still issues before IDLE; a partially packed word is discarded.
- SYNC_BYTE inside a frame is treated as ordinary data, not a restart.
- Reset mid-frame: immediate return to reset state. Any partial word is discarded and no write is issued.
- mem_chipselect and mem_write are identical signals. When mem_write=0, address, byteenable and writedata hold their last values.

Test Plan:
- Frame A5,10,00,08,00, bytes 01..08, csum 24 -> writes 0x04030201 @0x010 be=F, then 0x08070605 @0x011 be=F; done pulse; err_code=0; cpu_hold high from after A5 until the cycle after csum.
- LEN=6, data AA BB CC DD EE FF at addr 0x3FF -> 0xDDCCBBAA @0x3FF be=F, then 0x0000FFEE @0x000 be=4'b0011 (address wrap, partial word); done.
- Same as the first frame with csum 25 -> both writes occur; error pulse; err_code=1; no done.
- LEN=0x1001 -> error after LEN_H; err_code=2; no memory write; IDLE.
- After 3 data bytes of an 8-byte frame, no rx_valid for TIMEOUT_CYCLES (bench uses 100) -> error; err_code=3; no write of the partial word; a following valid frame loads correctly.
- rx_valid every cycle back-to-back for 16 data bytes -> 4 writes on consecutive-word addresses, none dropped. reset asserted mid-DATA -> all outputs 0 next cycle, no further writes.

Source files
------------

// File: rtl/nios_mem_loader.sv
// Loads a framed UART byte stream (sync, address, length, data, checksum) into the
// Nios program memory through a write-only Avalon-MM master, holding the CPU in reset meanwhile.
module nios_mem_loader #(
   parameter int          ADDR_W         = 10,
   parameter int          TIMEOUT_CYCLES = 5000000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]      LEN_MAX  = 17'(4 * (2 ** ADDR_W));

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CSUM = 2'd1;
   localparam logic [1:0] ERR_LEN  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR_L = 3'd1,
      S_ADDR_H = 3'd2,
      S_LEN_L  = 3'd3,
      S_LEN_H  = 3'd4,
      S_DATA   = 3'd5,
      S_CSUM   = 3'd6
   } state_t;

   state_t            state_r;
   logic [7:0]        addr_lo_r;
   logic [7:0]        len_lo_r;
   logic [ADDR_W-1:0] base_r;
   logic [15:0]       len_r;
   logic [15:0]       cnt_r;
   logic [7:0]        csum_r;
   logic [31:0]       pack_r;
   logic [TMO_W-1:0]  tmo_r;

   logic [ADDR_W-1:0] mem_address_r;
   logic [3:0]        mem_byteenable_r;
   logic              mem_write_r;
   logic [31:0]       mem_writedata_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;
   logic [1:0]        err_code_r;

   logic [31:0]       pack_next_s;
   logic [3:0]        lane_be_s;
   logic [15:0]       cnt_next_s;
   logic              last_byte_s;
   logic              word_end_s;
   logic              len_too_big_s;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      csum_add = acc + b;
   endfunction

   // Place the incoming byte on its lane and build the enables for lanes 0..current
   always_comb begin
      pack_next_s = pack_r;
      lane_be_s   = 4'b0000;
      case (cnt_r[1:0])
         2'd0: begin
            pack_next_s[7:0] = rx_data;
            lane_be_s        = 4'b0001;
         end
         2'd1: begin
            pack_next_s[15:8] = rx_data;
            lane_be_s         = 4'b0011;
         end
         2'd2: begin
            pack_next_s[23:16] = rx_data;
            lane_be_s          = 4'b0111;
         end
         2'd3: begin
            pack_next_s[31:24] = rx_data;
            lane_be_s          = 4'b1111;
         end
         default: begin
            pack_next_s = pack_r;
            lane_be_s   = 4'b0000;
         end
      endcase
   end

   // Frame position decodes used by the sequencer
   always_comb begin
      cnt_next_s    = cnt_r + 16'd1;
      last_byte_s   = (cnt_next_s == len_r);
      word_end_s    = (cnt_r[1:0] == 2'd3) || last_byte_s;
      len_too_big_s = ({1'b0, rx_data, len_lo_r} > LEN_MAX);
   end

   // Frame sequencer, packing datapath and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= S_IDLE;
         addr_lo_r        <= 8'h00;
         len_lo_r         <= 8'h00;
         base_r           <= '0;
         len_r            <= 16'h0000;
         cnt_r            <= 16'h0000;
         csum_r           <= 8'h00;
         pack_r           <= 32'h0000_0000;
         tmo_r            <= '0;
         mem_address_r    <= '0;
         mem_byteenable_r <= 4'b0000;
         mem_write_r      <= 1'b0;
         mem_writedata_r  <= 32'h0000_0000;
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
         error_r          <= 1'b0;
         err_code_r       <= ERR_NONE;
      end else begin
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         mem_write_r <= 1'b0;
         if (state_r == S_IDLE) begin
            tmo_r <= '0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_r    <= S_ADDR_L;
               busy_r     <= 1'b1;
               err_code_r <= ERR_NONE;
               cnt_r      <= 16'h0000;
               csum_r     <= 8'h00;
               pack_r     <= 32'h0000_0000;
            end
         end else if (!rx_valid) begin
            if (tmo_r == TMO_LAST) begin
               // A write already launched completes; an unfinished packed word is dropped
               state_r    <= S_IDLE;
               busy_r     <= 1'b0;
               error_r    <= 1'b1;
               err_code_r <= ERR_TMO;
               pack_r     <= 32'h0000_0000;
               tmo_r      <= '0;
            end else begin
               tmo_r <= tmo_r + TMO_W'(1);
            end
         end else begin
            tmo_r <= '0;
            case (state_r)
               S_ADDR_L: begin
                  addr_lo_r <= rx_data;
                  state_r   <= S_ADDR_H;
               end
               S_ADDR_H: begin
                  base_r  <= ADDR_W'({rx_data, addr_lo_r});
                  state_r <= S_LEN_L;
               end
               S_LEN_L: begin
                  len_lo_r <= rx_data;
                  state_r  <= S_LEN_H;
               end
               S_LEN_H: begin
                  len_r <= {rx_data, len_lo_r};
                  if (len_too_big_s) begin
                     state_r    <= S_IDLE;
                     busy_r     <= 1'b0;
                     error_r    <= 1'b1;
                     err_code_r <= ERR_LEN;
                  end else if ({rx_data, len_lo_r} == 16'h0000) begin
                     state_r <= S_CSUM;
                  end else begin
                     state_r <= S_DATA;
                  end
               end
               S_DATA: begin
                  cnt_r  <= cnt_next_s;
                  csum_r <= csum_add(csum_r, rx_data);
                  if (word_end_s) begin
                     mem_write_r      <= 1'b1;
                     mem_address_r    <= base_r + cnt_r[ADDR_W+1:2];
                     mem_byteenable_r <= lane_be_s;
                     mem_writedata_r  <= pack_next_s;
                     pack_r           <= 32'h0000_0000;
                  end else begin
                     pack_r <= pack_next_s;
                  end
                  if (last_byte_s) begin
                     state_r <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
                  if (rx_data == csum_r) begin
                     done_r <= 1'b1;
                  end else begin
                     error_r    <= 1'b1;
                     err_code_r <= ERR_CSUM;
                  end
               end
               default: begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mem_address    = mem_address_r;
   assign mem_byteenable = mem_byteenable_r;
   assign mem_chipselect = mem_write_r;
   assign mem_write      = mem_write_r;
   assign mem_writedata  = mem_writedata_r;
   assign cpu_hold       = busy_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign error          = error_r;
   assign err_code       = err_code_r;

   nios_mem_loader_chk u_chk (
      .clk            (clk),
      .reset          (reset),
      .done           (done_r),
      .error          (error_r),
      .mem_write      (mem_write),
      .mem_chipselect (mem_chipselect),
      .busy           (busy),
      .cpu_hold       (cpu_hold)
   );

endmodule

// Structural invariants of the loader outputs.
module nios_mem_loader_chk (
   input logic clk,
   input logic reset,
   input logic done,
   input logic error,
   input logic mem_write,
   input logic mem_chipselect,
   input logic busy,
   input logic cpu_hold
);

   a_pulse_excl : assert property (@(posedge clk) disable iff (reset) !(done && error));
   a_cs_eq_wr   : assert property (@(posedge clk) disable iff (reset) mem_write == mem_chipselect);
   a_hold_busy  : assert property (@(posedge clk) disable iff (reset) busy == cpu_hold);
   a_end_idle   : assert property (@(posedge clk) disable iff (reset) (done || error) |-> !busy);

endmodule

// File: tb/tb_nios_mem_loader.sv
// Randomised frame traffic against a frame-level reference model, plus literal
// expectations for the hand-worked frames.
module tb_nios_mem_loader;

   localparam int ADDR_W = 10;
   localparam int TMO    = 100;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              error;
   logic [1:0]        err_code;

   nios_mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   bit          started = 1'b0;
   bit          m_busy = 1'b0;
   int          pos = 0;
   int          idle_cnt = 0;
   int          start = 0;
   int          len = 0;
   logic [7:0]  alo = 8'h00;
   logic [7:0]  llo = 8'h00;
   logic [7:0]  data [0:4095];
   logic        m_write = 1'b0;
   logic        m_done = 1'b0;
   logic        m_error = 1'b0;
   logic [1:0]  m_code = 2'd0;
   logic [9:0]  m_addr = 10'd0;
   logic [3:0]  m_be = 4'd0;
   logic [31:0] m_wd = 32'd0;

   always @(posedge clk) begin
      int k;
      int w;
      int lane;
      int s;
      logic [31:0] word;
      started = 1'b1;
      m_write = 1'b0;
      m_done  = 1'b0;
      m_error = 1'b0;
      if (reset) begin
         m_busy = 1'b0; m_code = 2'd0; m_addr = 10'd0; m_be = 4'd0; m_wd = 32'd0;
         idle_cnt = 0; pos = 0;
      end else if (m_busy) begin
         if (!rx_valid) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
               m_busy = 1'b0; m_error = 1'b1; m_code = 2'd3;
            end
         end else begin
            idle_cnt = 0;
            if (pos == 1) alo = rx_data;
            else if (pos == 2) start = int'({rx_data, alo}) % 1024;
            else if (pos == 3) llo = rx_data;
            else if (pos == 4) begin
               len = int'({rx_data, llo});
               if (len > 4096) begin
                  m_busy = 1'b0; m_error = 1'b1; m_code = 2'd2;
               end
            end else begin
               k = pos - 5;
               if (k < len) begin
                  data[k] = rx_data;
                  lane = k % 4;
                  w = k / 4;
                  if (lane == 3 || k == len - 1) begin
                     word = 32'd0;
                     for (int j = 0; j <= lane; j++) word = word | (32'(data[4*w+j]) << (8*j));
                     m_write = 1'b1;
                     m_addr  = 10'((start + w) % 1024);
                     m_be    = 4'((1 << (lane + 1)) - 1);
                     m_wd    = word;
                  end
               end else begin
                  s = 0;
                  for (int j = 0; j < len; j++) s = s + int'(data[j]);
                  if (rx_data == 8'(s % 256)) m_done = 1'b1;
                  else begin
                     m_error = 1'b1; m_code = 2'd1;
                  end
                  m_busy = 1'b0;
               end
            end
            pos++;
         end
      end else if (rx_valid && rx_data == 8'hA5) begin
         m_busy = 1'b1; pos = 1; idle_cnt = 0; m_code = 2'd0;
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   typedef struct packed {
      logic [9:0]  a;
      logic [3:0]  be;
      logic [31:0] d;
   } wr_t;

   wr_t wlog[$];
   int  n_done = 0;
   int  n_err = 0;

   always @(negedge clk) begin
      if (started) begin
         chk("mem_write", mem_write, m_write);
         chk("mem_chipselect", mem_chipselect, m_write);
         chk("mem_address", mem_address, m_addr);
         chk("mem_byteenable", mem_byteenable, m_be);
         chk("mem_writedata", mem_writedata, m_wd);
         chk("busy", busy, m_busy);
         chk("cpu_hold", cpu_hold, m_busy);
         chk("done", done, m_done);
         chk("error", error, m_error);
         chk("err_code", err_code, m_code);
         if (mem_write === 1'b1) wlog.push_back({mem_address, mem_byteenable, mem_writedata});
         if (done === 1'b1) n_done++;
         if (error === 1'b1) n_err++;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] pl[$];

   task automatic cyc(input logic v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00);
   endtask

   task automatic sendb(input logic [7:0] b, input int maxgap);
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      cyc(1'b1, b);
   endtask

   task automatic clear_log();
      wlog.delete();
      n_done = 0;
      n_err = 0;
   endtask

   task automatic send_frame(input logic [15:0] addr, input logic [15:0] flen, input int maxgap,
                             input logic [7:0] delta, input int cut);
      logic [7:0] s;
      s = 8'h00;
      sendb(8'hA5, maxgap);
      sendb(addr[7:0], maxgap);
      sendb(addr[15:8], maxgap);
      sendb(flen[7:0], maxgap);
      sendb(flen[15:8], maxgap);
      if (flen > 16'd4096) return;
      for (int i = 0; i < int'(flen); i++) begin
         if (cut >= 0 && i == cut) begin
            idle(TMO + 5);
            return;
         end
         sendb(pl[i], maxgap);
         s = s + pl[i];
      end
      sendb(s + delta, maxgap);
   endtask

   task automatic fill_seq(input logic [7:0] first, input int n);
      logic [7:0] b;
      b = first;
      pl.delete();
      for (int i = 0; i < n; i++) begin
         pl.push_back(b);
         b = b + 8'd1;
      end
   endtask

   task automatic exp_wr(input int i, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
      if (i < wlog.size()) begin
         chk("lit_addr", wlog[i].a, a);
         chk("lit_be", wlog[i].be, be);
         chk("lit_data", wlog[i].d, d);
      end else begin
         checks++;
         errors++;
         $display("FAIL lit_write%0d: got %0d writes, expected more", i, wlog.size());
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      idle(3);
      chk("rst_busy", busy, 1'b0);
      chk("rst_write", mem_write, 1'b0);
      chk("rst_addr", mem_address, 10'd0);
      chk("rst_code", err_code, 2'd0);
      reset = 1'b0;
      idle(2);

      // Frame A: two full words, good checksum (0x24)
      clear_log();
      fill_seq(8'h01, 8);
      send_frame(16'h0010, 16'd8, 0, 8'h00, -1);
      idle(3);
      chk("A_nwr", wlog.size(), 2);
      exp_wr(0, 10'h010, 4'hF, 32'h0403_0201);
      exp_wr(1, 10'h011, 4'hF, 32'h0807_0605);
      chk("A_done", n_done, 1);
      chk("A_err", n_err, 0);
      chk("A_code", err_code, 2'd0);

      // Wrap and partial last word
      clear_log();
      pl.delete();
      pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC);
      pl.push_back(8'hDD); pl.push_back(8'hEE); pl.push_back(8'hFF);
      send_frame(16'h03FF, 16'd6, 2, 8'h00, -1);
      idle(3);
      chk("W_nwr", wlog.size(), 2);
      exp_wr(0, 10'h3FF, 4'hF, 32'hDDCC_BBAA);
      exp_wr(1, 10'h000, 4'h3, 32'h0000_FFEE);
      chk("W_done", n_done, 1);

      // Bad checksum (0x25): writes stand, error code 1
      clear_log();
      fill_seq(8'h01, 8);
      send_frame(16'h0010, 16'd8, 1, 8'h01, -1);
      idle(3);
      chk("C_nwr", wlog.size(), 2);
      chk("C_done", n_done, 0);
      chk("C_err", n_err, 1);
      chk("C_code", err_code, 2'd1);

      // Oversized length
      clear_log();
      send_frame(16'h0000, 16'h1001, 0, 8'h00, -1);
      idle(3);
      chk("L_nwr", wlog.size(), 0);
      chk("L_err", n_err, 1);
      chk("L_code", err_code, 2'd2);
      chk("L_busy", busy, 1'b0);

      // Timeout after 3 data bytes; one gap of TMO-1 must not expire
      clear_log();
      cyc(1'b1, 8'hA5); cyc(1'b1, 8'h40); cyc(1'b1, 8'h00); cyc(1'b1, 8'h08); cyc(1'b1, 8'h00);
      cyc(1'b1, 8'h11);
      idle(TMO - 1);
      cyc(1'b1, 8'h22); cyc(1'b1, 8'h33);
      idle(TMO + 5);
      chk("T_nwr", wlog.size(), 0);
      chk("T_err", n_err, 1);
      chk("T_code", err_code, 2'd3);
      clear_log();
      fill_seq(8'h01, 8);
      send_frame(16'h0010, 16'd8, 0, 8'h00, -1);
      idle(3);
      chk("T2_nwr", wlog.size(), 2);
      chk("T2_done", n_done, 1);
      chk("T2_code", err_code, 2'd0);

      // Back-to-back 16 bytes
      clear_log();
      fill_seq(8'h00, 16);
      send_frame(16'h0020, 16'd16, 0, 8'h00, -1);
      idle(3);
      chk("B_nwr", wlog.size(), 4);
      exp_wr(0, 10'h020, 4'hF, 32'h0302_0100);
      exp_wr(1, 10'h021, 4'hF, 32'h0706_0504);
      exp_wr(2, 10'h022, 4'hF, 32'h0B0A_0908);
      exp_wr(3, 10'h023, 4'hF, 32'h0F0E_0D0C);
      chk("B_done", n_done, 1);

      // Reset in the middle of DATA
      clear_log();
      cyc(1'b1, 8'hA5); cyc(1'b1, 8'h00); cyc(1'b1, 8'h01); cyc(1'b1, 8'h10); cyc(1'b1, 8'h00);
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'(i + 1));
      reset = 1'b1;
      cyc(1'b1, 8'h77);
      reset = 1'b0;
      chk("R_busy", busy, 1'b0);
      chk("R_hold", cpu_hold, 1'b0);
      chk("R_write", mem_write, 1'b0);
      chk("R_wdata", mem_writedata, 32'd0);
      idle(5);
      chk("R_nwr", wlog.size(), 1);
      exp_wr(0, 10'h100, 4'hF, 32'h0403_0201);

      // Boundaries: maximum length, zero length
      fill_seq(8'h5A, 4096);
      send_frame(16'h0200, 16'd4096, 0, 8'h00, -1);
      idle(2);
      clear_log();
      send_frame(16'h0001, 16'd0, 1, 8'h00, -1);
      idle(2);
      chk("Z_nwr", wlog.size(), 0);
      chk("Z_done", n_done, 1);

      // Random traffic
      for (int f = 0; f < 40; f++) begin
         int          flen;
         int          cut;
         logic [7:0]  delta;
         logic [7:0]  nb;
         repeat ($urandom_range(3, 0)) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h00;
            cyc(1'($urandom_range(1, 0)), nb);
         end
         flen = $urandom_range(20, 0);
         pl.delete();
         for (int i = 0; i < flen; i++) pl.push_back(8'($urandom));
         cut = ($urandom_range(9, 0) == 0) ? $urandom_range(flen, 0) : -1;
         delta = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         send_frame(16'($urandom), 16'(flen), $urandom_range(3, 0), delta, cut);
         idle(2);
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
